// File: rtl/modem_link_ctrl.sv
// Hamming (8,4) SEC-DED transfer sequencer for the ASK modem loopback.
// Encodes, settles, samples on tick, decodes and retries bad samples.
module modem_link_ctrl #(
    parameter int SETTLE_CYC = 16,
    parameter int MAX_RETRY  = 3,
    parameter int CNT_W      = 8
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       origin,
    input  logic             sample_tick,
    input  logic [7:0]       received,
    output logic [7:0]       sent,
    output logic             busy,
    output logic             done,
    output logic [3:0]       decoded,
    output logic             err_corr,
    output logic             err_fail,
    output logic [3:0]       retry_cnt,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] fail_count
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        WAIT_TICK,
        DECODE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    cap;

    logic [2:0]    syn;
    logic          par;
    logic [7:0]    flip;
    logic [7:0]    fixed;
    logic          dec_corr;
    logic          dec_bad;
    logic [3:0]    dec_data;

    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [6:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        return {^c, c};
    endfunction

    // Syndrome/parity classification of the captured word
    always_comb begin
        syn = {cap[3] ^ cap[4] ^ cap[5] ^ cap[6],
               cap[1] ^ cap[2] ^ cap[5] ^ cap[6],
               cap[0] ^ cap[2] ^ cap[4] ^ cap[6]};
        par = ^cap;
        flip = 8'd0;
        if (par && syn != 3'd0)
            flip[syn - 3'd1] = 1'b1;
        fixed    = cap ^ flip;
        dec_corr = par;
        dec_bad  = !par && syn != 3'd0;
        dec_data = {fixed[6], fixed[5], fixed[4], fixed[2]};
    end

    // Transfer sequencer with registered outputs and statistics
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cap        <= 8'd0;
            sent       <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            decoded    <= 4'd0;
            err_corr   <= 1'b0;
            err_fail   <= 1'b0;
            retry_cnt  <= 4'd0;
            corr_count <= '0;
            fail_count <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sent      <= enc(origin);
                        retry_cnt <= 4'd0;
                        busy      <= 1'b1;
                        err_corr  <= 1'b0;
                        err_fail  <= 1'b0;
                        cnt       <= CW'(SETTLE_CYC - 1);
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0)
                        state <= WAIT_TICK;
                    else
                        cnt <= cnt - CW'(1);
                end
                WAIT_TICK: begin
                    if (sample_tick) begin
                        cap   <= received;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (!dec_bad) begin
                        decoded  <= dec_data;
                        err_corr <= dec_corr;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                        if (dec_corr && corr_count != '1)
                            corr_count <= corr_count + CNT_W'(1);
                    end else if (retry_cnt < 4'(MAX_RETRY)) begin
                        retry_cnt <= retry_cnt + 4'd1;
                        cnt       <= CW'(SETTLE_CYC - 1);
                        state     <= SETTLE;
                    end else begin
                        decoded  <= {cap[6], cap[5], cap[4], cap[2]};
                        err_fail <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                        if (fail_count != '1)
                            fail_count <= fail_count + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modem_link_ctrl.sv
// Directed bench for modem_link_ctrl.
// Hand-computed codewords, latencies and flags.
module tb_modem_link_ctrl;

    localparam int CNT_W = 2;

    logic             sys_clk;
    logic             reset;
    logic             start;
    logic [3:0]       origin;
    logic             sample_tick;
    logic [7:0]       received;
    logic [7:0]       sent;
    logic             busy;
    logic             done;
    logic [3:0]       decoded;
    logic             err_corr;
    logic             err_fail;
    logic [3:0]       retry_cnt;
    logic [CNT_W-1:0] corr_count;
    logic [CNT_W-1:0] fail_count;

    logic       loop_en;
    logic [7:0] rx_val;
    int         tick_per;
    int         cyc;
    int         checks;
    int         fails;

    assign received = loop_en ? sent : rx_val;

    modem_link_ctrl #(
        .SETTLE_CYC(16),
        .MAX_RETRY (3),
        .CNT_W     (CNT_W)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .start      (start),
        .origin     (origin),
        .sample_tick(sample_tick),
        .received   (received),
        .sent       (sent),
        .busy       (busy),
        .done       (done),
        .decoded    (decoded),
        .err_corr   (err_corr),
        .err_fail   (err_fail),
        .retry_cnt  (retry_cnt),
        .corr_count (corr_count),
        .fail_count (fail_count)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
        sample_tick = (tick_per == 0) ? 1'b1 : (cyc % tick_per == 0);
    endtask

    task automatic xfer(input string tag, input logic [3:0] org,
                        input int exp_lat, input logic [7:0] exp_sent,
                        input logic [3:0] exp_dec, input logic exp_corr,
                        input logic exp_fail, input logic [3:0] exp_rty,
                        input bit sw, input bit poke);
        int n;
        origin = org;
        start  = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_sent"}, sent, exp_sent);
        chk({tag, "_clrflag"}, {err_corr, err_fail}, 0);
        n = 0;
        while (!done && n < 2000) begin
            step();
            n++;
            if (sw && n == 18)
                rx_val = 8'h55;
            if (poke) begin
                start = (n == 30);
                if (n == 30)
                    origin = 4'h1;
            end
        end
        start = 1'b0;
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_dec"}, decoded, exp_dec);
        chk({tag, "_flags"}, {err_corr, err_fail}, {exp_corr, exp_fail});
        chk({tag, "_retry"}, retry_cnt, exp_rty);
        chk({tag, "_bsyoff"}, busy, 0);
        chk({tag, "_senthold"}, sent, exp_sent);
        step();
        chk({tag, "_pulse"}, {done, busy}, 0);
    endtask

    initial begin
        checks      = 0;
        fails       = 0;
        cyc         = 0;
        tick_per    = 0;
        loop_en     = 1'b1;
        rx_val      = 8'h00;
        reset       = 1'b0;
        start       = 1'b0;
        origin      = 4'h0;
        sample_tick = 1'b1;
        step();
        step();
        chk("rst_sent", sent, 0);
        chk("rst_ctl", {busy, done, err_corr, err_fail}, 0);
        chk("rst_dec", {decoded, retry_cnt}, 0);
        chk("rst_cnt", {corr_count, fail_count}, 0);
        reset = 1'b1;
        step();

        xfer("clean", 4'hB, 18, 8'h55, 4'hB, 0, 0, 0, 0, 0);
        chk("clean_cnt", {corr_count, fail_count}, 0);

        loop_en = 1'b0;
        rx_val  = 8'h45;
        xfer("bit4", 4'hB, 18, 8'h55, 4'hB, 1, 0, 0, 0, 0);
        chk("bit4_cc", corr_count, 1);

        rx_val = 8'hD5;
        xfer("bit7", 4'hB, 18, 8'h55, 4'hB, 1, 0, 0, 0, 0);
        chk("bit7_cc", corr_count, 2);

        rx_val = 8'h56;
        xfer("dbl", 4'hB, 72, 8'h55, 4'hB, 0, 1, 3, 0, 0);
        chk("dbl_fc", fail_count, 1);
        chk("dbl_cc", corr_count, 2);

        rx_val = 8'h56;
        xfer("rty1", 4'hB, 36, 8'h55, 4'hB, 0, 0, 1, 1, 0);
        chk("rty1_cnt", {corr_count, fail_count}, {2'd2, 2'd1});

        loop_en  = 1'b1;
        tick_per = 64;
        while (cyc % 64 != 59)
            step();
        xfer("tick", 4'hB, 70, 8'h55, 4'hB, 0, 0, 0, 0, 1);
        tick_per = 0;
        step();
        xfer("org1", 4'h1, 18, 8'h87, 4'h1, 0, 0, 0, 0, 0);

        origin = 4'hB;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++)
            step();
        chk("mid_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_sent", sent, 0);
        chk("mid_ctl", {busy, done, err_corr, err_fail}, 0);
        chk("mid_cnt", {corr_count, fail_count, retry_cnt, decoded}, 0);
        #4;
        reset = 1'b1;
        step();
        chk("mid_nodone", {done, busy}, 0);
        xfer("post", 4'hB, 18, 8'h55, 4'hB, 0, 0, 0, 0, 0);
        chk("post_cnt", {corr_count, fail_count}, 0);

        loop_en = 1'b0;
        rx_val  = 8'h45;
        for (int i = 0; i < 5; i++)
            xfer("sat", 4'hB, 18, 8'h55, 4'hB, 1, 0, 0, 0, 0);
        chk("sat_cc", corr_count, 3);
        chk("sat_fc", fail_count, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
